// File: rtl/alu_operand_sel_buf.sv
// ALU source-A operand mux feeding a 2-entry registered skid buffer (head + skid)
// with a valid/ready handshake and a sticky out-of-range select flag.
module alu_operand_sel_buf #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_flat,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               occ,
  output logic                     sel_err,
  input  logic                     err_clr
);

  // Out-of-range selects yield an all-zero operand rather than X or aliasing.
  function automatic logic [WIDTH-1:0] sel_operand(
    input logic [NUM_SRC*WIDTH-1:0] flat,
    input logic [SEL_W-1:0]         s
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (32'(s) == 32'(i)) v = flat[i*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  logic [WIDTH-1:0] r_head;
  logic             r_head_vld;
  logic [WIDTH-1:0] r_skid;
  logic             r_skid_vld;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_sel_val;
  logic             w_sel_oob;
  logic             w_acc;
  logic             w_pop;

  assign w_sel_val = sel_operand(src_flat, sel);
  assign w_sel_oob = (32'(sel) >= 32'(NUM_SRC));
  assign w_acc     = in_valid & ~r_skid_vld;
  assign w_pop     = r_head_vld & out_ready;

  // Capture stage: the skid only ever fills while the head is occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_head_vld <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
    end else if (!r_head_vld) begin
      if (w_acc) begin
        r_head     <= w_sel_val;
        r_head_vld <= 1'b1;
      end
    end else if (!r_skid_vld) begin
      if (w_acc && w_pop) begin
        r_head <= w_sel_val;
      end else if (w_acc) begin
        r_skid     <= w_sel_val;
        r_skid_vld <= 1'b1;
      end else if (w_pop) begin
        r_head_vld <= 1'b0;
      end
    end else if (w_pop) begin
      r_head     <= r_skid;
      r_skid_vld <= 1'b0;
    end
  end

  // Set has priority over clear on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_acc && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  assign in_ready  = ~r_skid_vld;
  assign out_data  = r_head;
  assign out_valid = r_head_vld;
  assign occ       = {r_head_vld & r_skid_vld, r_head_vld ^ r_skid_vld};
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_alu_operand_sel_buf.sv
// Directed and randomised checks of alu_operand_sel_buf with a 3-source mux
// and a queue model for the buffer contents.
module tb_alu_operand_sel_buf;
  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 3;
  localparam int SEL_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_SRC*WIDTH-1:0] src_flat;
  logic [SEL_W-1:0]         sel;
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               occ;
  logic                     sel_err;
  logic                     err_clr;

  int n_vec = 0;
  int n_err = 0;

  alu_operand_sel_buf #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .src_flat(src_flat), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .occ(occ),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [WIDTH-1:0] v);
    src_flat[idx*WIDTH +: WIDTH] = v;
  endtask

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_v;
  logic [WIDTH-1:0] prev_data;
  logic             pend, m_acc, m_pop, stalled;
  int               acc_cnt;

  initial begin
    reset = 1'b1; src_flat = '0; sel = '0; in_valid = 1'b0;
    out_ready = 1'b0; err_clr = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_sel_err", 32'(sel_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    // First accept on the first edge after reset release
    set_src(0, 32'h11); set_src(1, 32'h40); set_src(2, 32'h22);
    sel = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    #10 reset = 1'b0;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 1);
    chk("t1_out_data", out_data, 32'h40);
    chk("t1_occ", 32'(occ), 1);
    step();
    chk("t1_drain_occ", 32'(occ), 0);
    chk("t1_drain_valid", 32'(out_valid), 0);

    // Back-to-back pushes into a stalled consumer
    out_ready = 1'b0; sel = 2'd0; in_valid = 1'b1;
    set_src(0, 32'hA); step();
    chk("t2_occ1", 32'(occ), 1);
    chk("t2_ready1", 32'(in_ready), 1);
    set_src(0, 32'hB); step();
    chk("t2_occ2", 32'(occ), 2);
    chk("t2_ready2", 32'(in_ready), 0);
    chk("t2_head_a", out_data, 32'hA);
    set_src(0, 32'hC); step();
    chk("t2_hold_occ", 32'(occ), 2);
    chk("t2_hold_ready", 32'(in_ready), 0);
    chk("t2_hold_data", out_data, 32'hA);
    out_ready = 1'b1; step();
    chk("t2_out_b", out_data, 32'hB);
    chk("t2_occ_b", 32'(occ), 1);
    chk("t2_ready_b", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t2_out_c", out_data, 32'hC);
    chk("t2_occ_c", 32'(occ), 1);
    step();
    chk("t2_empty", 32'(occ), 0);

    // Streaming: one accept and one pop per cycle
    acc_cnt = 0;
    in_valid = 1'b1; out_ready = 1'b1; sel = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      set_src(2, WIDTH'(k));
      if (in_ready) acc_cnt++;
      step();
      chk("t3_data", out_data, WIDTH'(k));
      chk("t3_occ", 32'(occ), 1);
    end
    chk("t3_accepts", acc_cnt, 8);
    in_valid = 1'b0; step();
    chk("t3_empty", 32'(occ), 0);

    // Out-of-range select
    set_src(0, 32'hDEAD); set_src(1, 32'hBEEF); set_src(2, 32'hCAFE);
    sel = 2'd3; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("t4_oob_data", out_data, 0);
    chk("t4_oob_valid", 32'(out_valid), 1);
    chk("t4_sel_err", 32'(sel_err), 1);
    err_clr = 1'b1; step();
    err_clr = 1'b0;
    chk("t4_cleared", 32'(sel_err), 0);
    err_clr = 1'b1; in_valid = 1'b1; step();
    err_clr = 1'b0; in_valid = 1'b0;
    chk("t4_set_wins", 32'(sel_err), 1);
    sel = 2'd1; in_valid = 1'b1; step();
    in_valid = 1'b0;
    chk("t4_inrange_data", out_data, 32'hBEEF);
    chk("t4_sticky", 32'(sel_err), 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_clr2", 32'(sel_err), 0);
    step();

    // Asynchronous reset with a full buffer
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    set_src(0, 32'h1); step();
    set_src(0, 32'h2); step();
    in_valid = 1'b0;
    chk("t5_full", 32'(occ), 2);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 0);
    chk("t5_rst_occ", 32'(occ), 0);
    chk("t5_rst_ready", 32'(in_ready), 1);
    chk("t5_rst_data", out_data, 0);
    #1 reset = 1'b0;
    set_src(0, 32'h55); in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_post_valid", 32'(out_valid), 1);
    chk("t5_post_data", out_data, 32'h55);
    step();
    chk("t5_post_empty", 32'(occ), 0);

    // Random handshake against a queue model
    q.delete(); pend = 1'b0; exp_v = '0; stalled = 1'b0; prev_data = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1'b1;
        sel = SEL_W'($urandom_range(0, 3));
        for (int s = 0; s < NUM_SRC; s++) set_src(s, WIDTH'($urandom));
        exp_v = (32'(sel) < NUM_SRC) ? src_flat[32'(sel)*WIDTH +: WIDTH] : '0;
      end
      in_valid  = pend;
      out_ready = ($urandom_range(0, 3) != 0);
      m_acc = pend && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      stalled   = (q.size() > 0) && !out_ready;
      prev_data = out_data;
      step();
      if (m_pop) void'(q.pop_front());
      if (m_acc) begin
        q.push_back(exp_v);
        pend = 1'b0;
      end
      chk("rnd_occ", 32'(occ), q.size());
      chk("rnd_ready", 32'(in_ready), (q.size() < 2) ? 1 : 0);
      chk("rnd_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) chk("rnd_data", out_data, q[0]);
      if (stalled) chk("rnd_stable", out_data, prev_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
